// File: rtl/autoc_ctrl_pkg.sv
// Shared types and constants for the autocorrelator sequencer/detector.
// State encoding, settings-register offsets and ctrl bit positions.
package autoc_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWarmup  = 3'd1,
      StSearch  = 3'd2,
      StHoldoff = 3'd3,
      StDone    = 3'd4
   } state_e;

   localparam int unsigned RegCtrl   = 0;
   localparam int unsigned RegThresh = 1;
   localparam int unsigned RegRuncfg = 2;

   localparam int unsigned CtrlRun     = 0;
   localparam int unsigned CtrlOneshot = 1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

endpackage

// File: rtl/autoc_mag.sv
// Stage 1: registered |si| + |sq| with its sample-valid flag.
// The result is WIDTH+1 bits, so the most negative input needs no saturation.
module autoc_mag #(
   parameter int unsigned WIDTH = 24
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   input  logic signed [WIDTH-1:0] i_si,
   input  logic signed [WIDTH-1:0] i_sq,
   output logic        [WIDTH:0]   o_mag,
   output logic                    o_valid
);

   logic [WIDTH:0] w_si_ext;
   logic [WIDTH:0] w_sq_ext;
   logic [WIDTH:0] w_si_abs;
   logic [WIDTH:0] w_sq_abs;
   logic [WIDTH:0] r_mag;
   logic           r_valid;

   assign w_si_ext = {i_si[WIDTH-1], i_si};
   assign w_sq_ext = {i_sq[WIDTH-1], i_sq};
   assign w_si_abs = i_si[WIDTH-1] ? (~w_si_ext + (WIDTH+1)'(1)) : w_si_ext;
   assign w_sq_abs = i_sq[WIDTH-1] ? (~w_sq_ext + (WIDTH+1)'(1)) : w_sq_ext;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mag   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_mag   <= w_si_abs + w_sq_abs;
         r_valid <= i_valid;
      end
   end

   assign o_mag   = r_mag;
   assign o_valid = r_valid;

endmodule

// File: rtl/autoc_ctrl.sv
// Sequencer/detector for the autocorrelator: settings decode, warm-up discard,
// run-length threshold detection with holdoff and one-shot modes.
module autoc_ctrl
   import autoc_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH  = 24,
   parameter int unsigned BASE   = 0,
   parameter int unsigned WARMUP = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_set_stb,
   input  logic [7:0]              i_set_addr,
   input  logic [31:0]             i_set_data,
   input  logic                    i_strobe_in,
   input  logic                    i_outputting,
   input  logic signed [WIDTH-1:0] i_si,
   input  logic signed [WIDTH-1:0] i_sq,
   output logic                    o_autoc_enable,
   output logic                    o_detect,
   output logic                    o_busy,
   output logic [15:0]             o_detect_count
);

   localparam logic [7:0]  AddrCtrl   = 8'(BASE + RegCtrl);
   localparam logic [7:0]  AddrThresh = 8'(BASE + RegThresh);
   localparam logic [7:0]  AddrRuncfg = 8'(BASE + RegRuncfg);
   localparam logic [31:0] WarmupLast = 32'(WARMUP - 1);

   state_e         r_state, w_state_d;
   logic [1:0]     r_ctrl;
   logic [WIDTH:0] r_thresh;
   logic [WIDTH:0] r_thr_s1;
   logic [31:0]    r_runcfg;
   logic [31:0]    r_wu_cnt, w_wu_cnt_d;
   logic [15:0]    r_run_cnt, w_run_cnt_d;
   logic [15:0]    r_ho_cnt, w_ho_cnt_d;
   logic [15:0]    r_det_cnt, w_det_cnt_d;
   logic           r_detect, w_fire;

   logic [WIDTH:0] w_mag;
   logic           w_v, w_v1, w_above, w_busy;
   logic           w_run, w_oneshot;
   logic [15:0]    w_min_run, w_holdoff;
   logic [16:0]    w_run_len, w_min_eff;

   assign w_run     = r_ctrl[CtrlRun];
   assign w_oneshot = r_ctrl[CtrlOneshot];
   assign w_min_run = r_runcfg[15:0];
   assign w_holdoff = r_runcfg[31:16];
   assign w_busy    = (r_state == StWarmup) || (r_state == StSearch) || (r_state == StHoldoff);
   assign w_v       = i_strobe_in & i_outputting & w_busy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ctrl   <= '0;
         r_thresh <= '0;
         r_thr_s1 <= '0;
         r_runcfg <= '0;
      end else begin
         // Threshold travels with the sample so a same-cycle write hits the next one.
         r_thr_s1 <= r_thresh;
         if (i_set_stb && i_set_addr == AddrCtrl) begin
            r_ctrl <= {i_set_data[CtrlOneshot], i_set_data[CtrlRun]};
         end
         if (i_set_stb && i_set_addr == AddrThresh) r_thresh <= i_set_data[WIDTH:0];
         if (i_set_stb && i_set_addr == AddrRuncfg) r_runcfg <= i_set_data;
      end
   end

   autoc_mag #(
      .WIDTH (WIDTH)
   ) u_mag (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_v),
      .i_si    (i_si),
      .i_sq    (i_sq),
      .o_mag   (w_mag),
      .o_valid (w_v1)
   );

   assign w_above   = w_mag > r_thr_s1;
   assign w_run_len = {1'b0, r_run_cnt} + 17'd1;
   assign w_min_eff = (w_min_run == 16'd0) ? 17'd1 : {1'b0, w_min_run};

   always_comb begin
      w_state_d   = r_state;
      w_wu_cnt_d  = r_wu_cnt;
      w_run_cnt_d = r_run_cnt;
      w_ho_cnt_d  = r_ho_cnt;
      w_det_cnt_d = r_det_cnt;
      w_fire      = 1'b0;
      if (!w_run) begin
         w_state_d = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state_d   = StWarmup;
               w_wu_cnt_d  = '0;
               w_run_cnt_d = '0;
               w_det_cnt_d = '0;
            end
            StWarmup: begin
               if (WARMUP == 0) begin
                  w_state_d = StSearch;
               end else if (w_v1) begin
                  if (r_wu_cnt == WarmupLast) w_state_d = StSearch;
                  else w_wu_cnt_d = r_wu_cnt + 32'd1;
               end
            end
            StSearch: begin
               if (w_v1 && w_above) begin
                  if (w_run_len >= w_min_eff) begin
                     w_fire      = 1'b1;
                     w_det_cnt_d = sat_inc16(r_det_cnt);
                     w_run_cnt_d = '0;
                     w_ho_cnt_d  = '0;
                     w_state_d   = w_oneshot ? StDone : StHoldoff;
                  end else begin
                     w_run_cnt_d = sat_inc16(r_run_cnt);
                  end
               end else if (w_v1) begin
                  w_run_cnt_d = '0;
               end
            end
            StHoldoff: begin
               if (w_holdoff == 16'd0) begin
                  w_state_d   = StSearch;
                  w_run_cnt_d = '0;
               end else if (w_v1) begin
                  if (r_ho_cnt == w_holdoff - 16'd1) begin
                     w_state_d   = StSearch;
                     w_run_cnt_d = '0;
                  end else begin
                     w_ho_cnt_d = r_ho_cnt + 16'd1;
                  end
               end
            end
            StDone:  w_state_d = StDone;
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_wu_cnt  <= '0;
         r_run_cnt <= '0;
         r_ho_cnt  <= '0;
         r_det_cnt <= '0;
         r_detect  <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_wu_cnt  <= w_wu_cnt_d;
         r_run_cnt <= w_run_cnt_d;
         r_ho_cnt  <= w_ho_cnt_d;
         r_det_cnt <= w_det_cnt_d;
         r_detect  <= w_fire;
      end
   end

   assign o_autoc_enable = w_busy;
   assign o_busy         = w_busy;
   assign o_detect       = r_detect;
   assign o_detect_count = r_det_cnt;

endmodule

// File: tb/tb_autoc_ctrl.sv
// Directed bench for autoc_ctrl: sample-level reference model compared every
// cycle, plus hand-computed detect timing and count expectations.
module tb_autoc_ctrl;

   localparam int unsigned W      = 24;
   localparam int unsigned TbBase = 16;
   localparam int unsigned TbWarm = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                set_stb = 1'b0;
   logic [7:0]          set_addr = '0;
   logic [31:0]         set_data = '0;
   logic                strobe_in = 1'b0;
   logic                outputting = 1'b0;
   logic signed [W-1:0] si = '0;
   logic signed [W-1:0] sq = '0;
   logic                autoc_enable, detect, busy;
   logic [15:0]         detect_count;

   autoc_ctrl #(
      .WIDTH  (W),
      .BASE   (TbBase),
      .WARMUP (TbWarm)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_set_stb      (set_stb),
      .i_set_addr     (set_addr),
      .i_set_data     (set_data),
      .i_strobe_in    (strobe_in),
      .i_outputting   (outputting),
      .i_si           (si),
      .i_sq           (sq),
      .o_autoc_enable (autoc_enable),
      .o_detect       (detect),
      .o_busy         (busy),
      .o_detect_count (detect_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int s_cyc = 0;
   int dq[$];
   int cq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model, per sample: phase 0 off, 1 warm-up, 2 search, 3 holdoff, 4 done.
   int m_phase = 0, m_warm_left = 0, m_hold_left = 0, m_run_len = 0, m_count = 0;
   int m_thr = 0, m_min = 0, m_hold = 0;
   bit m_run = 0, m_oneshot = 0, m_det = 0;
   bit s1_v = 0;
   int s1_mag = 0, s1_thr = 0;

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_phase = 0; m_warm_left = 0; m_hold_left = 0; m_run_len = 0; m_count = 0;
         m_thr = 0; m_min = 0; m_hold = 0; m_run = 0; m_oneshot = 0; m_det = 0;
         s1_v = 0; s1_mag = 0; s1_thr = 0;
      end else begin
         bit en, v;
         en = (m_phase >= 1 && m_phase <= 3);
         v = strobe_in && outputting && en;
         m_det = 0;
         if (!m_run) begin
            m_phase = 0;
         end else if (m_phase == 0) begin
            m_phase = 1; m_warm_left = TbWarm; m_run_len = 0; m_count = 0;
         end else if (m_phase == 1) begin
            if (m_warm_left == 0) m_phase = 2;
            else if (s1_v) begin
               m_warm_left--;
               if (m_warm_left == 0) m_phase = 2;
            end
         end else if (m_phase == 2) begin
            if (s1_v && s1_mag > s1_thr) begin
               if (m_run_len < 65535) m_run_len++;
               if (m_run_len >= ((m_min == 0) ? 1 : m_min)) begin
                  m_det = 1;
                  if (m_count < 65535) m_count++;
                  m_run_len = 0;
                  if (m_oneshot) m_phase = 4;
                  else begin m_phase = 3; m_hold_left = m_hold; end
               end
            end else if (s1_v) m_run_len = 0;
         end else if (m_phase == 3) begin
            if (m_hold_left == 0) begin m_phase = 2; m_run_len = 0; end
            else if (s1_v) begin
               m_hold_left--;
               if (m_hold_left == 0) begin m_phase = 2; m_run_len = 0; end
            end
         end
         s1_v = v;
         s1_mag = iabs(int'(si)) + iabs(int'(sq));
         s1_thr = m_thr;
         if (set_stb && set_addr == 8'(TbBase + 0)) begin
            m_run = set_data[0]; m_oneshot = set_data[1];
         end
         if (set_stb && set_addr == 8'(TbBase + 1)) m_thr = int'(set_data[24:0]);
         if (set_stb && set_addr == 8'(TbBase + 2)) begin
            m_min = int'(set_data[15:0]); m_hold = int'(set_data[31:16]);
         end
      end
   end

   // Cycle-by-cycle comparison against the model, plus detect logging.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("enable", autoc_enable, (m_phase >= 1 && m_phase <= 3));
         chk("busy", busy, (m_phase >= 1 && m_phase <= 3));
         chk("detect", detect, m_det);
         chk("detect_count", detect_count, m_count);
         if (detect) begin
            dq.push_back(cyc);
            cq.push_back(int'(detect_count));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      set_stb = 1'b1; set_addr = 8'(TbBase + off); set_data = d;
      tick();
      set_stb = 1'b0;
   endtask

   task automatic feed(input int a, input int b);
      strobe_in = 1'b1; outputting = 1'b1; si = W'(a); sq = W'(b); s_cyc = cyc;
      tick();
   endtask

   task automatic idle(input int n);
      strobe_in = 1'b0;
      repeat (n) tick();
   endtask

   int t2_si[6] = '{-700, 1500, 400, 1500, 1000, 1500};
   int t2_sq[6] = '{800, 0, -500, 0, -500, 0};
   int c5;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_enable", autoc_enable, 0);
      chk("reset_busy", busy, 0);
      chk("reset_detect", detect, 0);
      chk("reset_count", detect_count, 0);
      tick();

      // Warm-up: first 4 samples discarded, detect 2 cycles after the 5th.
      wr(2, 32'h0000_0001);
      wr(1, 32'd100);
      wr(0, 32'd1);
      tick();
      dq.delete();
      repeat (5) feed(500, 0);
      idle(4);
      chk("warm_ndet", dq.size(), 1);
      if (dq.size() > 0) chk("warm_det_time", dq[0], s_cyc + 2);
      chk("warm_count", detect_count, 1);

      // Run length 3 with a below-threshold break.
      wr(0, 32'd0);
      wr(1, 32'd1000);
      wr(2, 32'h0000_0003);
      wr(0, 32'd1);
      tick();
      repeat (TbWarm) feed(5000, 0);
      dq.delete();
      for (int i = 0; i < 6; i++) feed(t2_si[i], t2_sq[i]);
      idle(4);
      chk("run_ndet", dq.size(), 1);
      if (dq.size() > 0) chk("run_det_time", dq[0], s_cyc + 2);
      chk("run_count", detect_count, 1);

      // Boundaries: equal magnitude does not detect; |-2^23| exceeds 2^23-1.
      wr(2, 32'h0000_0001);
      dq.delete();
      feed(1000, 0);
      idle(4);
      chk("eq_ndet", dq.size(), 0);
      wr(1, 32'h007F_FFFF);
      feed(-(1 << 23), 0);
      idle(4);
      chk("absmin_ndet", dq.size(), 1);
      if (dq.size() > 0) chk("absmin_det_time", dq[0], s_cyc + 2);
      chk("absmin_count", detect_count, 2);

      // Continuous with holdoff 5: detects 6 samples apart.
      wr(0, 32'd0);
      wr(2, 32'h0005_0001);
      wr(1, 32'd100);
      wr(0, 32'd1);
      tick();
      dq.delete(); cq.delete();
      c5 = 0;
      for (int i = 1; i <= 23; i++) begin
         feed(500, -20);
         if (i == 5) c5 = s_cyc;
      end
      idle(4);
      chk("ho_ndet", dq.size(), 4);
      if (dq.size() >= 4) begin
         chk("ho_first", dq[0], c5 + 2);
         for (int i = 0; i < 3; i++) chk("ho_spacing", dq[i+1] - dq[i], 6);
         for (int i = 0; i < 3; i++) chk("ho_count_seq", cq[i], i + 1);
      end

      // One-shot: single detect then DONE; restart clears the count.
      wr(0, 32'd0);
      wr(0, 32'd3);
      tick();
      dq.delete();
      repeat (TbWarm + 10) feed(500, 0);
      idle(3);
      chk("os_ndet", dq.size(), 1);
      chk("os_enable", autoc_enable, 0);
      chk("os_busy", busy, 0);
      chk("os_count", detect_count, 1);
      wr(0, 32'd0);
      wr(0, 32'd1);
      tick();
      chk("restart_busy", busy, 1);
      chk("restart_count", detect_count, 0);

      // Abort: run cleared in the cycle the qualifying sample is strobed.
      dq.delete();
      repeat (TbWarm) feed(500, 0);
      set_stb = 1'b1; set_addr = 8'(TbBase); set_data = 32'd0;
      feed(500, 0);
      set_stb = 1'b0;
      strobe_in = 1'b0;
      tick();
      chk("abort_busy", busy, 0);
      chk("abort_enable", autoc_enable, 0);
      idle(3);
      chk("abort_ndet", dq.size(), 0);

      // Asynchronous reset while in holdoff.
      wr(0, 32'd1);
      tick();
      repeat (TbWarm + 1) feed(500, 0);
      idle(3);
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_count", detect_count, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_enable", autoc_enable, 0);
      chk("arst_busy", busy, 0);
      chk("arst_detect", detect, 0);
      chk("arst_count", detect_count, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      idle(4);
      chk("post_rst_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/autoc_ctrl.md
Name: autoc_ctrl

Overview:
- Sequencer and detector for the autocorrelator core.
- Programmed over the settings bus; enables the core and discards warm-up output.
- Compares the correlation magnitude |si|+|sq| against a programmable threshold and pulses `detect` after a run of consecutive above-threshold samples.
- Enforces a holdoff after each detection and supports one-shot and continuous modes. Sits between the DSP settings bus and the autoc instance in the receive chain.

Parameters:
- WIDTH, 24, width of signed si/sq from the autocorrelator.
- BASE, 0, settings-bus base address (uses BASE..BASE+2).
- WARMUP, 32, number of valid samples discarded after the core begins outputting.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- strobe_in  in  1  sample strobe (same as the core's ddc_out_strobe)
- outputting  in  1  core reports valid correlation output
- si  in  WIDTH  signed in-phase correlation
- sq  in  WIDTH  signed quadrature correlation
- autoc_enable  out  1  enable to the core
- detect  out  1  one-cycle detection pulse
- busy  out  1  high in WARMUP/SEARCH/HOLDOFF
- detect_count  out  16  saturating count of detections since run rose

Behaviour:
- Asynchronous reset clears all registers. Outputs reset to 0: autoc_enable, detect, busy, detect_count. State resets to IDLE; ctrl, thresh and runcfg registers reset to 0.
- Settings registers (written when set_stb and set_addr matches):
  - BASE+0 ctrl: bit0 = run, bit1 = oneshot.
  - BASE+1 thresh: bits[WIDTH:0], unsigned.
  - BASE+2 runcfg: bits[15:0] = min_run, bits[31:16] = holdoff.
  - Writes take effect the cycle after set_stb. Threshold and runcfg changes mid-SEARCH apply to the next compare; run_cnt is not cleared.
- Sample valid: v = strobe_in & outputting & autoc_enable.
- Stage 1 (registered):
  - mag = |si| + |sq|, WIDTH+1 bits unsigned.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1), no saturation needed.
  - v1 = v.
- Stage 2 compare: above = mag > thresh (strict).
- State machine (transitions on clk):
  - IDLE: autoc_enable=0. Enter WARMUP when run=1. On entry, clear wu_cnt and run_cnt, and clear detect_count on run 0→1.
  - WARMUP: autoc_enable=1. wu_cnt increments on v1. Go to SEARCH when wu_cnt == WARMUP-1 and v1. WARMUP=0 means go to SEARCH immediately.
  - SEARCH: on v1, if above then run_cnt++ else run_cnt=0. If above and run_cnt+1 >= max(min_run,1), then:
    - pulse detect the next cycle,
    - detect_count++ (saturates at 0xFFFF),
    - clear run_cnt,
    - go to DONE if oneshot, else HOLDOFF.
    - min_run=0 behaves as 1.
  - HOLDOFF: ho_cnt counts v1. Return to SEARCH after holdoff valid samples, with run_cnt=0. holdoff=0 means return to SEARCH on the next cycle.
  - DONE: autoc_enable=0, busy=0. Stays here until run=0, then goes to IDLE.
- Latency: detect rises exactly 2 clk cycles after the strobe_in cycle carrying the qualifying sample.
- run=0 in any state goes to IDLE the next cycle. In-flight detection is suppressed; autoc_enable drops the same edge.
- Samples with outputting=0 are ignored, not counted as below threshold.
- Simultaneous strobe and set_stb: the compare uses the old thresh.
- run_cnt is 16 bits and saturates at 0xFFFF.
- busy = state ∈ {WARMUP, SEARCH, HOLDOFF}.

Decomposition:
- Shared package holds:
  - state encoding IDLE/WARMUP/SEARCH/HOLDOFF/DONE (3 bits),
  - register offsets CTRL=0, THRESH=1, RUNCFG=2,
  - ctrl bit indices RUN=0, ONESHOT=1.
- One sub-module, autoc_mag: registered |si|+|sq| with valid pipeline (stage 1).
- Settings decode reuses the existing setting_reg instances.

Test Plan:
- Warm-up: WARMUP=4, run=1, outputting=1, strobe every cycle, mag always above → detect not asserted during the first 4 strobes. First detect comes on the 5th sample (min_run=1), 2 cycles after its strobe.
- Run length: thresh=1000, min_run=3, stimulus mags 1500,1500,900,1500,1500,1500 → exactly one detect, 2 cycles after the 6th strobe; detect_count=1.
- Boundary: mag==thresh (1000 vs 1000) → no detect. si=-2^23, sq=0 with thresh=2^23-1 → detect, proving the abs(min) case.
- Holdoff, continuous: holdoff=5, min_run=1, mag always above → detects spaced exactly 6 valid samples apart; detect_count increments 1,2,3.
- One-shot: oneshot=1 → single detect, then state DONE with autoc_enable=0 and busy=0. Writing run=0 then run=1 restarts WARMUP and clears detect_count to 0.
- Abort/reset: write run=0 the same cycle a qualifying sample reaches stage 1 → no detect, IDLE next cycle. Assert rst asynchronously mid-HOLDOFF → all outputs 0 immediately, before the next clk edge.
